mem_loader: RTL and testbench

Program-image loader that drives the RAM512x32 override write port. It accepts a byte stream on a valid/ready handshake and packs every 4 bytes into one 32-bit word. Each word is written to consecutive RAM addresses starting at a programmed base. While loading, it holds the CPU (Control/DataPath) in reset, so memory contents are stable before execution starts.

---
 rtl/mem_loader_pkg.sv | 27 ++
 rtl/mem_loader_word_assembler.sv | 44 ++++
 rtl/mem_loader.sv | 171 +++++++++++++++++
 tb/tb_mem_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// mem_loader_pkg
// Shared definitions for the program-image loader: FSM state encoding,
// word/byte geometry of the RAM512x32 target, and a small address helper.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int RAM_DEPTH      = 512;
   localparam int BYTE_WIDTH     = 8;
   localparam int RAM_AW         = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Write address for word 'index' of a load; the 9-bit sum wraps 0x1FF -> 0x000.
   function automatic logic [RAM_AW-1:0] word_addr(input logic [RAM_AW-1:0] base,
                                                   input logic [RAM_AW:0]   index);
      return base + index[RAM_AW-1:0];
   endfunction

endpackage

// File: rtl/mem_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
// Packs a little-endian byte stream into 32-bit words. Byte k of a word lands
// in bits [8k+7:8k]; o_word_valid pulses in the cycle the 4th byte is accepted
// so the word is complete in r_word from the following cycle on.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_clear       discard any partial word (driven by the loader FSM)
//   i_accept      a byte is taken this cycle
//   i_byte        byte to place
//   o_word        assembled word
//   o_word_valid  high with the accept of the last byte of a word
// ----------------------------------------------------------------------------
module word_assembler
   import mem_loader_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_clear,
   input  logic                          i_accept,
   input  logic [BYTE_WIDTH-1:0]         i_byte,
   output logic [BYTES_PER_WORD*8-1:0]   o_word,
   output logic                          o_word_valid
);

   logic [1:0]                  r_byte_cnt;
   logic [BYTES_PER_WORD*8-1:0] r_word;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_accept) begin
         r_word[{r_byte_cnt, 3'b000} +: BYTE_WIDTH] <= i_byte;
         r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = i_accept && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// ----------------------------------------------------------------------------
// mem_loader
// Program-image loader for the RAM512x32 override write port. Bytes arrive on
// a valid/ready handshake, are packed 4-per-word (little-endian) and written
// to consecutive addresses from a latched base. The CPU is held while a load
// is in progress.
//
// Optional feature: define LOADER_CHECKSUM_EN to get a running 32-bit sum of
// the written words on 'checksum'; otherwise 'checksum' is tied to 0.
//
// Ports
//   Clock            system clock (rising edge)
//   reset            synchronous active-high reset
//   start            begin a load (only looked at in IDLE)
//   base_addr        first RAM address, latched on start
//   word_count       words to load, 0..512, latched on start
//   byte_data        stream byte
//   byte_valid       byte_data valid
//   byte_ready       loader takes a byte this cycle
//   overide          one-cycle RAM write strobe
//   overide_address  write address (0 when overide=0)
//   overide_data_in  write data (0 when overide=0)
//   cpu_hold         keeps the CPU stopped during a load
//   busy             not idle
//   done             one-cycle end-of-load pulse
//   checksum         sum of written words (0 without LOADER_CHECKSUM_EN)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start, all outputs low
// COLLECT  | accepting bytes until a word is complete
// WRITE    | driving one override write of the assembled word
// DONE     | one-cycle done pulse, CPU still held
// ----------------------------------------------------------------------------
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
)
(
   input  logic                  Clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            byte_data,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  overide,
   output logic [ADDR_WIDTH-1:0] overide_address,
   output logic [DATA_WIDTH-1:0] overide_data_in,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum
);

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   r_index;
   logic [ADDR_WIDTH:0]   w_index_next;
   logic                  w_start_load;
   logic                  w_accept;
   logic                  w_clear;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_word_valid;

   assign w_start_load = (r_state == ST_IDLE) && start;
   assign w_index_next = r_index + 1'b1;
   assign w_accept     = byte_valid && byte_ready;
   // Holding the assembler clear while idle guarantees every load starts on
   // byte 0, even after an aborted load.
   assign w_clear      = (r_state == ST_IDLE);

   word_assembler u_word_assembler (
      .i_clk        (Clock),
      .i_rst        (reset),
      .i_clear      (w_clear),
      .i_accept     (w_accept),
      .i_byte       (byte_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // state register
   always_ff @(posedge Clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = (word_count == '0) ? ST_DONE : ST_COLLECT;
         end
         ST_COLLECT: begin
            if (w_word_valid) w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            w_next_state = (w_index_next == r_count) ? ST_DONE : ST_COLLECT;
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      byte_ready      = 1'b0;
      overide         = 1'b0;
      overide_address = '0;
      overide_data_in = '0;
      cpu_hold        = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            busy       = 1'b1;
         end
         ST_WRITE: begin
            overide         = 1'b1;
            overide_address = word_addr(r_base, r_index);
            overide_data_in = w_word;
            cpu_hold        = 1'b1;
            busy            = 1'b1;
         end
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b1;
            busy     = 1'b1;
         end
         default: ;
      endcase
   end

   // load parameters and word index
   always_ff @(posedge Clock) begin
      if (reset) begin
         r_base  <= '0;
         r_count <= '0;
         r_index <= '0;
      end else if (w_start_load) begin
         r_base  <= base_addr;
         r_count <= word_count;
         r_index <= '0;
      end else if (r_state == ST_WRITE) begin
         r_index <= w_index_next;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_checksum;

   always_ff @(posedge Clock) begin
      if (reset || w_start_load) r_checksum <= '0;
      else if (r_state == ST_WRITE) r_checksum <= r_checksum + w_word;
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

   logic        Clock = 1'b0;
   logic        reset;
   logic        start;
   logic [8:0]  base_addr;
   logic [9:0]  word_count;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        overide;
   logic [8:0]  overide_address;
   logic [31:0] overide_data_in;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   mem_loader dut (
      .Clock           (Clock),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .word_count      (word_count),
      .byte_data       (byte_data),
      .byte_valid      (byte_valid),
      .byte_ready      (byte_ready),
      .overide         (overide),
      .overide_address (overide_address),
      .overide_data_in (overide_data_in),
      .cpu_hold        (cpu_hold),
      .busy            (busy),
      .done            (done),
      .checksum        (checksum)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] data;
   } wr_t;

   int          total = 0;
   int          bad   = 0;
   wr_t         obs_w[$];
   wr_t         exp_w[$];
   logic [7:0]  acc_q[$];
   logic [7:0]  sent_q[$];
   int          gate_err = 0;
   int          done_cnt = 0;
   logic [31:0] exp_sum;
   wr_t         mon_t;

   // Passive observation: write strobes, accepted bytes, done pulses, gating.
   always @(negedge Clock) begin
      if (overide === 1'b1) begin
         mon_t.addr = overide_address;
         mon_t.data = overide_data_in;
         obs_w.push_back(mon_t);
      end else if (overide_address !== 9'd0 || overide_data_in !== 32'd0) begin
         gate_err++;
      end
      if (byte_valid === 1'b1 && byte_ready === 1'b1) acc_q.push_back(byte_data);
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_obs();
      obs_w.delete();
      exp_w.delete();
      acc_q.delete();
      gate_err = 0;
      done_cnt = 0;
   endtask

   // Reference model: words from the byte list, little-endian, wrapping addresses.
   task automatic build_exp(input logic [8:0] b, input int c);
      wr_t t;
      exp_w.delete();
      exp_sum = 32'd0;
      for (int i = 0; i < c; i++) begin
         t.addr = 9'((int'(b) + i) % 512);
         t.data = {sent_q[4*i+3], sent_q[4*i+2], sent_q[4*i+1], sent_q[4*i]};
         exp_w.push_back(t);
         exp_sum = exp_sum + t.data;
      end
`ifndef LOADER_CHECKSUM_EN
      exp_sum = 32'd0;
`endif
   endtask

   task automatic do_start(input logic [8:0] b, input logic [9:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      base_addr  = 9'($urandom);
      word_count = 10'($urandom);
   endtask

   // gap < 0: random 0..2 idle cycles before each byte; otherwise fixed gap.
   task automatic feed(input int gap);
      int idx = 0;
      int guard = 0;
      int idle;
      logic acc;
      while (idx < sent_q.size() && guard < 4000) begin
         idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         repeat (idle) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            tick();
            guard++;
         end
         byte_valid = 1'b1;
         byte_data  = sent_q[idx];
         acc = 1'b0;
         while (!acc && guard < 4000) begin
            acc = byte_ready;
            tick();
            guard++;
         end
         idx++;
      end
      byte_valid = 1'b0;
      if (guard >= 4000) begin
         total++; bad++;
         $display("FAIL feed_timeout: sent %0d of %0d bytes", idx, sent_q.size());
      end
   endtask

   task automatic run_load(input string name, input logic [8:0] b, input int c,
                           input int gap, input bit preset);
      int w;
      clear_obs();
      if (!preset) begin
         sent_q.delete();
         for (int i = 0; i < 4*c; i++) sent_q.push_back(8'($urandom));
      end
      build_exp(b, c);
      do_start(b, 10'(c));
      feed(gap);
      w = 0;
      while (done !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL %s done_latency: got %0d cycles after last write, want 1", name, w);
      end
      tick();
      total++;
      if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL %s idle_after_done: busy=%b cpu_hold=%b done=%b want 0 0 0", name, busy, cpu_hold, done);
      end
      total++;
      if (obs_w.size() != exp_w.size()) begin
         bad++;
         $display("FAIL %s write_count: got %0d want %0d", name, obs_w.size(), exp_w.size());
      end else begin
         for (int i = 0; i < exp_w.size(); i++) begin
            total++;
            if (obs_w[i].addr !== exp_w[i].addr || obs_w[i].data !== exp_w[i].data) begin
               bad++;
               $display("FAIL %s write[%0d]: got %h/%h want %h/%h", name, i,
                        obs_w[i].addr, obs_w[i].data, exp_w[i].addr, exp_w[i].data);
            end
         end
      end
      total++;
      if (acc_q.size() != sent_q.size()) begin
         bad++;
         $display("FAIL %s accepted_bytes: got %0d want %0d", name, acc_q.size(), sent_q.size());
      end else begin
         for (int i = 0; i < sent_q.size(); i++) begin
            if (acc_q[i] !== sent_q[i]) begin
               total++; bad++;
               $display("FAIL %s byte[%0d]: got %h want %h", name, i, acc_q[i], sent_q[i]);
            end
         end
      end
      total++;
      if (gate_err != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL %s gating/done: gate_err=%0d done_pulses=%0d want 0 1", name, gate_err, done_cnt);
      end
      total++;
      if (checksum !== exp_sum) begin
         bad++;
         $display("FAIL %s checksum: got %h want %h", name, checksum, exp_sum);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
      base_addr = 9'd0; word_count = 10'd0;
      tick(); tick();
      total++;
      if ({byte_ready, overide, cpu_hold, busy, done} !== 5'b0 ||
          overide_address !== 9'd0 || overide_data_in !== 32'd0 || checksum !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b hold=%b busy=%b done=%b addr=%h data=%h sum=%h want all 0",
                  byte_ready, overide, cpu_hold, busy, done, overide_address, overide_data_in, checksum);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_word();
      logic [7:0] bs[4];
      bs[0] = 8'h78; bs[1] = 8'h56; bs[2] = 8'h34; bs[3] = 8'h12;
      clear_obs();
      do_start(9'h000, 10'd1);
      total++;
      if (byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
         bad++;
         $display("FAIL single ready_after_start: got rdy=%b hold=%b want 1 1", byte_ready, cpu_hold);
      end
      for (int i = 0; i < 4; i++) begin
         byte_valid = 1'b1;
         byte_data  = bs[i];
         tick();
      end
      byte_valid = 1'b0;
      total++;
      if (overide !== 1'b1 || overide_address !== 9'h000 ||
          overide_data_in !== 32'h12345678 || byte_ready !== 1'b0) begin
         bad++;
         $display("FAIL single write: got ov=%b addr=%h data=%h rdy=%b want 1 000 12345678 0",
                  overide, overide_address, overide_data_in, byte_ready);
      end
      tick();
      total++;
      if (done !== 1'b1 || overide !== 1'b0 || cpu_hold !== 1'b1) begin
         bad++;
         $display("FAIL single done: got done=%b ov=%b hold=%b want 1 0 1", done, overide, cpu_hold);
      end
      tick();
      total++;
      if (done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single release: got done=%b hold=%b busy=%b want 0 0 0", done, cpu_hold, busy);
      end
      total++;
      if (obs_w.size() != 1) begin
         bad++;
         $display("FAIL single write_count: got %0d want 1", obs_w.size());
      end
   endtask

   task automatic test_wrap();
      run_load("wrap", 9'h1FF, 3, 0, 1'b0);
   endtask

   task automatic test_handshake();
      run_load("gap2", 9'h040, 2, 2, 1'b0);
      // valid held high through WRITE cycles
      run_load("valid_held", 9'h100, 3, 0, 1'b0);
   endtask

   task automatic test_zero_count();
      clear_obs();
      do_start(9'h033, 10'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || overide !== 1'b0 || byte_ready !== 1'b0) begin
         bad++;
         $display("FAIL zero done: got done=%b busy=%b ov=%b rdy=%b want 1 1 0 0", done, busy, overide, byte_ready);
      end
      base_addr  = 9'h000;
      word_count = 10'd1;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
         bad++;
         $display("FAIL zero start_ignored: got busy=%b done=%b rdy=%b want 0 0 0", busy, done, byte_ready);
      end
      tick();
      total++;
      if (busy !== 1'b0 || obs_w.size() != 0 || done_cnt != 1) begin
         bad++;
         $display("FAIL zero aftermath: got busy=%b writes=%0d done_pulses=%0d want 0 0 1", busy, obs_w.size(), done_cnt);
      end
   endtask

   task automatic test_reset_mid_load();
      clear_obs();
      do_start(9'h0A5, 10'd2);
      byte_valid = 1'b1; byte_data = 8'hAA; tick();
      byte_valid = 1'b1; byte_data = 8'hBB; tick();
      byte_valid = 1'b0;
      reset = 1'b1;
      tick();
      total++;
      if ({byte_ready, overide, cpu_hold, busy, done} !== 5'b0 ||
          overide_address !== 9'd0 || overide_data_in !== 32'd0 || checksum !== 32'd0) begin
         bad++;
         $display("FAIL midreset outputs: got rdy=%b ov=%b hold=%b busy=%b done=%b sum=%h want all 0",
                  byte_ready, overide, cpu_hold, busy, done, checksum);
      end
      reset = 1'b0;
      tick();
      total++;
      if (obs_w.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midreset no_write: got writes=%0d busy=%b want 0 0", obs_w.size(), busy);
      end
      run_load("post_reset", 9'h005, 1, 0, 1'b0);
   endtask

   task automatic test_checksum();
      logic [31:0] want;
      sent_q.delete();
      for (int w = 1; w <= 3; w++) begin
         sent_q.push_back(8'(w));
         sent_q.push_back(8'd0);
         sent_q.push_back(8'd0);
         sent_q.push_back(8'd0);
      end
      run_load("checksum", 9'h010, 3, -1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      want = 32'd6;
`else
      want = 32'd0;
`endif
      repeat (3) tick();
      total++;
      if (checksum !== want) begin
         bad++;
         $display("FAIL checksum_hold: got %h want %h", checksum, want);
      end
   endtask

   task automatic test_random();
      logic [8:0] b;
      int c;
      for (int n = 0; n < 8; n++) begin
         b = 9'($urandom);
         c = int'($urandom_range(1, 5));
         run_load("random", b, c, -1, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      run_load("b2b_a", 9'h1FE, 4, 0, 1'b0);
      run_load("b2b_b", 9'h1FD, 2, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_wrap();
      test_handshake();
      test_zero_count();
      test_reset_mid_load();
      test_checksum();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
